// File: rtl/datapath.sv
// Datapath for a small 32-bit processor.
// A single shared 32-bit bus connects the general registers (R6, R7), the
// program counter, the instruction register, the ALU operand latch Y, the
// 64-bit result register Z, HI/LO, and the memory interface registers
// MAR/MDR. One source drives the bus at a time. A priority encoder picks
// that source from the select requests, and a mux places it on the bus.
// Every register loads from the bus. MDR can also load from memory, and Z
// loads the ALU output.
module datapath (
    input  logic        clk,
    input  logic        clear,

    // register load enables
    input  logic        r6_enable,
    input  logic        r7_enable,
    input  logic        PC_enable,
    input  logic        IR_enable,
    input  logic        Y_enable,
    input  logic        Z_enable,
    input  logic        MAR_enable,
    input  logic        MDR_enable,
    input  logic        HI_enable,
    input  logic        LO_enable,

    // Z input and MDR input steering
    input  logic        PC_increment_enable,
    input  logic        read,

    // bus source requests
    input  logic        r6_select,
    input  logic        r7_select,
    input  logic        PC_select,
    input  logic        Z_HI_select,
    input  logic        Z_LO_select,
    input  logic        MDR_select,
    output logic [4:0]  encode_sel_signal,

    // ALU control and memory data
    input  logic [4:0]  alu_instruction,
    input  logic [31:0] MDataIN,

    // observation outputs
    output logic [31:0] bus_Data,
    output logic [63:0] aluResult,
    output logic [31:0] R6_Data,
    output logic [31:0] R7_Data,
    output logic [31:0] PC_Data,
    output logic [31:0] IR_Data,
    output logic [31:0] Y_Data,
    output logic [31:0] HI_Data,
    output logic [31:0] LO_Data,
    output logic [31:0] MAR_Data,
    output logic [31:0] MDR_Data,
    output logic [31:0] Z_HI_Data,
    output logic [31:0] Z_LO_Data
);

    // Bus source codes. Code 0 means that no source drives the bus.
    localparam logic [4:0] SRC_NONE = 5'd0;
    localparam logic [4:0] SRC_R6   = 5'd6;
    localparam logic [4:0] SRC_R7   = 5'd7;
    localparam logic [4:0] SRC_ZHI  = 5'd18;
    localparam logic [4:0] SRC_ZLO  = 5'd19;
    localparam logic [4:0] SRC_PC   = 5'd20;
    localparam logic [4:0] SRC_MDR  = 5'd21;

    // ALU opcodes
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    logic [63:0] z_reg;

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic [5:0]  shamt_inv;
    logic [63:0] product;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic [31:0] result32;

    assign Z_HI_Data = z_reg[63:32];
    assign Z_LO_Data = z_reg[31:0];

    assign op_a  = Y_Data;
    assign op_b  = bus_Data;
    assign shamt = op_b[4:0];
    // For a zero shift amount this gives a shift of 32, which clears the
    // wrapped-around half. The rotate then reduces to the operand itself.
    assign shamt_inv = 6'd32 - {1'b0, shamt};

    // Both operands are sign-extended to 64 bits so the product keeps all
    // 64 bits of the signed result.
    assign product = $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});

    // Priority encoder: MDR has the highest priority, then PC, Z_LO, Z_HI, R7, R6.
    always_comb begin
        encode_sel_signal = SRC_NONE;
        if (MDR_select)
            encode_sel_signal = SRC_MDR;
        else if (PC_select)
            encode_sel_signal = SRC_PC;
        else if (Z_LO_select)
            encode_sel_signal = SRC_ZLO;
        else if (Z_HI_select)
            encode_sel_signal = SRC_ZHI;
        else if (r7_select)
            encode_sel_signal = SRC_R7;
        else if (r6_select)
            encode_sel_signal = SRC_R6;
    end

    // Bus mux: codes without a source, including code 0, drive zero onto the bus.
    always_comb begin
        case (encode_sel_signal)
            SRC_R6:  bus_Data = R6_Data;
            SRC_R7:  bus_Data = R7_Data;
            SRC_ZHI: bus_Data = z_reg[63:32];
            SRC_ZLO: bus_Data = z_reg[31:0];
            SRC_PC:  bus_Data = PC_Data;
            SRC_MDR: bus_Data = MDR_Data;
            default: bus_Data = 32'h0;
        endcase
    end

    // Signed divider. A zero divisor yields zero. The single overflow case
    // (most negative value divided by -1) is handled explicitly so it never
    // reaches the simulator's division operator.
    always_comb begin
        quotient  = 32'h0;
        remainder = 32'h0;
        if (op_b == 32'h0) begin
            quotient  = 32'h0;
            remainder = 32'h0;
        end else if (op_a == 32'h8000_0000 && op_b == 32'hFFFF_FFFF) begin
            quotient  = 32'h8000_0000;
            remainder = 32'h0;
        end else begin
            quotient  = $signed(op_a) / $signed(op_b);
            remainder = $signed(op_a) % $signed(op_b);
        end
    end

    // 32-bit ALU operations. Each result is zero-extended into the 64-bit Z input.
    always_comb begin
        case (alu_instruction)
            OP_ADD, OP_ADDI: result32 = op_a + op_b;
            OP_SUB:          result32 = op_a - op_b;
            OP_SHR:          result32 = op_a >> shamt;
            OP_SHRA:         result32 = $unsigned($signed(op_a) >>> shamt);
            OP_SHL:          result32 = op_a << shamt;
            OP_ROR:          result32 = (op_a >> shamt) | (op_a << shamt_inv);
            OP_ROL:          result32 = (op_a << shamt) | (op_a >> shamt_inv);
            OP_AND, OP_ANDI: result32 = op_a & op_b;
            OP_OR, OP_ORI:   result32 = op_a | op_b;
            OP_NEG:          result32 = 32'h0 - op_b;
            OP_NOT:          result32 = ~op_b;
            default:         result32 = 32'h0;
        endcase
    end

    // Z input selection. PC increment overrides the opcode. Multiply and
    // divide use the full 64-bit width.
    always_comb begin
        aluResult = {32'h0, result32};
        if (PC_increment_enable)
            aluResult = {32'h0, bus_Data + 32'd1};
        else if (alu_instruction == OP_MUL)
            aluResult = product;
        else if (alu_instruction == OP_DIV)
            aluResult = {remainder, quotient};
    end

    // General-purpose registers R6 and R7 load from the bus.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            R6_Data <= 32'h0;
            R7_Data <= 32'h0;
        end else begin
            if (r6_enable) R6_Data <= bus_Data;
            if (r7_enable) R7_Data <= bus_Data;
        end
    end

    // Control registers PC, IR and MAR load from the bus.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            PC_Data  <= 32'h0;
            IR_Data  <= 32'h0;
            MAR_Data <= 32'h0;
        end else begin
            if (PC_enable)  PC_Data  <= bus_Data;
            if (IR_enable)  IR_Data  <= bus_Data;
            if (MAR_enable) MAR_Data <= bus_Data;
        end
    end

    // Arithmetic-side registers Y, HI and LO load from the bus.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            Y_Data  <= 32'h0;
            HI_Data <= 32'h0;
            LO_Data <= 32'h0;
        end else begin
            if (Y_enable)  Y_Data  <= bus_Data;
            if (HI_enable) HI_Data <= bus_Data;
            if (LO_enable) LO_Data <= bus_Data;
        end
    end

    // MDR loads from memory when read is high, otherwise from the bus.
    always_ff @(posedge clk or posedge clear) begin
        if (clear)
            MDR_Data <= 32'h0;
        else if (MDR_enable)
            MDR_Data <= read ? MDataIN : bus_Data;
    end

    // Z captures the full 64-bit ALU output.
    always_ff @(posedge clk or posedge clear) begin
        if (clear)
            z_reg <= 64'h0;
        else if (Z_enable)
            z_reg <= aluResult;
    end

endmodule

// File: tb/tb_datapath.sv
// Directed testbench for the datapath: register transfers, the encoder,
// the ALU operations, and asynchronous clear.
module tb_datapath;

    logic        clk;
    logic        clear;
    logic        r6_enable, r7_enable, PC_enable, IR_enable, Y_enable;
    logic        Z_enable, MAR_enable, MDR_enable, HI_enable, LO_enable;
    logic        PC_increment_enable, read;
    logic        r6_select, r7_select, PC_select, Z_HI_select, Z_LO_select, MDR_select;
    logic [4:0]  encode_sel_signal;
    logic [4:0]  alu_instruction;
    logic [31:0] MDataIN;
    logic [31:0] bus_Data;
    logic [63:0] aluResult;
    logic [31:0] R6_Data, R7_Data, PC_Data, IR_Data, Y_Data, HI_Data, LO_Data;
    logic [31:0] MAR_Data, MDR_Data, Z_HI_Data, Z_LO_Data;

    int checks   = 0;
    int failures = 0;

    datapath dut (
        .clk(clk), .clear(clear),
        .r6_enable(r6_enable), .r7_enable(r7_enable), .PC_enable(PC_enable),
        .IR_enable(IR_enable), .Y_enable(Y_enable), .Z_enable(Z_enable),
        .MAR_enable(MAR_enable), .MDR_enable(MDR_enable), .HI_enable(HI_enable),
        .LO_enable(LO_enable), .PC_increment_enable(PC_increment_enable), .read(read),
        .r6_select(r6_select), .r7_select(r7_select), .PC_select(PC_select),
        .Z_HI_select(Z_HI_select), .Z_LO_select(Z_LO_select), .MDR_select(MDR_select),
        .encode_sel_signal(encode_sel_signal), .alu_instruction(alu_instruction),
        .MDataIN(MDataIN), .bus_Data(bus_Data), .aluResult(aluResult),
        .R6_Data(R6_Data), .R7_Data(R7_Data), .PC_Data(PC_Data), .IR_Data(IR_Data),
        .Y_Data(Y_Data), .HI_Data(HI_Data), .LO_Data(LO_Data), .MAR_Data(MAR_Data),
        .MDR_Data(MDR_Data), .Z_HI_Data(Z_HI_Data), .Z_LO_Data(Z_LO_Data)
    );

    // free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic drive_idle();
        r6_enable = 0; r7_enable = 0; PC_enable = 0; IR_enable = 0; Y_enable = 0;
        Z_enable = 0; MAR_enable = 0; MDR_enable = 0; HI_enable = 0; LO_enable = 0;
        PC_increment_enable = 0; read = 0;
        r6_select = 0; r7_select = 0; PC_select = 0; Z_HI_select = 0;
        Z_LO_select = 0; MDR_select = 0;
        alu_instruction = 5'd0; MDataIN = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mdr(input logic [31:0] v);
        drive_idle();
        MDataIN = v; read = 1; MDR_enable = 1;
        tick();
        drive_idle();
    endtask

    task automatic load_y(input logic [31:0] v);
        load_mdr(v);
        MDR_select = 1; Y_enable = 1;
        tick();
        drive_idle();
    endtask

    task automatic test_reset();
        logic [31:0] obs [0:10];
        clear = 1;
        drive_idle();
        #2;
        obs = '{R6_Data, R7_Data, PC_Data, IR_Data, Y_Data, HI_Data, LO_Data,
                MAR_Data, MDR_Data, Z_HI_Data, Z_LO_Data};
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (obs[i] !== 32'h0) begin
                failures++;
                $display("[TB] FAIL reset_reg%0d got=%h exp=%h", i, obs[i], 32'h0);
            end
        end
        checks++;
        if (bus_Data !== 32'h0 || encode_sel_signal !== 5'd0) begin
            failures++;
            $display("[TB] FAIL reset_bus got=%h/%0d exp=0/0", bus_Data, encode_sel_signal);
        end
        @(negedge clk);
        clear = 0;
        tick();
    endtask

    task automatic test_encoder();
        logic [5:0] sel [0:11];
        logic [4:0] exp [0:11];
        sel = '{6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000,
                6'b111111, 6'b000011, 6'b001100, 6'b011000, 6'b000110, 6'b000000};
        exp = '{5'd6, 5'd7, 5'd18, 5'd19, 5'd20, 5'd21,
                5'd21, 5'd7, 5'd19, 5'd20, 5'd18, 5'd0};
        drive_idle();
        for (int i = 0; i < 12; i++) begin
            {MDR_select, PC_select, Z_LO_select, Z_HI_select, r7_select, r6_select} = sel[i];
            #1;
            checks++;
            if (encode_sel_signal !== exp[i]) begin
                failures++;
                $display("[TB] FAIL encoder_%b got=%0d exp=%0d", sel[i], encode_sel_signal, exp[i]);
            end
        end
        checks++;
        if (bus_Data !== 32'h0) begin
            failures++;
            $display("[TB] FAIL bus_none got=%h exp=%h", bus_Data, 32'h0);
        end
        drive_idle();
    endtask

    task automatic test_mdr_transfer();
        load_mdr(32'h12);
        checks++;
        if (MDR_Data !== 32'h12) begin
            failures++;
            $display("[TB] FAIL mdr_read got=%h exp=%h", MDR_Data, 32'h12);
        end
        MDR_select = 1; r6_enable = 1;
        #1;
        checks++;
        if (encode_sel_signal !== 5'd21 || bus_Data !== 32'h12) begin
            failures++;
            $display("[TB] FAIL mdr_to_bus got=%0d/%h exp=21/%h", encode_sel_signal, bus_Data, 32'h12);
        end
        tick();
        drive_idle();
        load_mdr(32'h14);
        MDR_select = 1; r7_enable = 1;
        #1;
        checks++;
        if (encode_sel_signal !== 5'd21) begin
            failures++;
            $display("[TB] FAIL mdr_sel_r7 got=%0d exp=21", encode_sel_signal);
        end
        tick();
        drive_idle();
        checks++;
        if (R6_Data !== 32'h12 || R7_Data !== 32'h14) begin
            failures++;
            $display("[TB] FAIL r6_r7_load got=%h/%h exp=12/14", R6_Data, R7_Data);
        end
        r6_select = 1;
        #1;
        checks++;
        if (bus_Data !== 32'h12 || encode_sel_signal !== 5'd6) begin
            failures++;
            $display("[TB] FAIL bus_r6 got=%h/%0d exp=12/6", bus_Data, encode_sel_signal);
        end
        drive_idle();
    endtask

    task automatic test_pc_fetch();
        drive_idle();
        PC_select = 1; MAR_enable = 1; PC_increment_enable = 1; Z_enable = 1;
        #1;
        checks++;
        if (aluResult !== 64'h1 || encode_sel_signal !== 5'd20) begin
            failures++;
            $display("[TB] FAIL pc_inc_comb got=%h/%0d exp=1/20", aluResult, encode_sel_signal);
        end
        tick();
        drive_idle();
        checks++;
        if (MAR_Data !== 32'h0 || Z_LO_Data !== 32'h1 || Z_HI_Data !== 32'h0) begin
            failures++;
            $display("[TB] FAIL pc_inc_z got=%h/%h/%h exp=0/1/0", MAR_Data, Z_LO_Data, Z_HI_Data);
        end
        Z_LO_select = 1; PC_enable = 1;
        tick();
        drive_idle();
        checks++;
        if (PC_Data !== 32'h1) begin
            failures++;
            $display("[TB] FAIL pc_update got=%h exp=%h", PC_Data, 32'h1);
        end
        load_mdr(32'h7B38_0000);
        MDR_select = 1; IR_enable = 1;
        tick();
        drive_idle();
        checks++;
        if (IR_Data !== 32'h7B38_0000) begin
            failures++;
            $display("[TB] FAIL ir_load got=%h exp=%h", IR_Data, 32'h7B38_0000);
        end
    endtask

    task automatic test_mul_lo_hi();
        drive_idle();
        r6_select = 1; Y_enable = 1;
        tick();
        drive_idle();
        checks++;
        if (Y_Data !== 32'h12) begin
            failures++;
            $display("[TB] FAIL y_from_r6 got=%h exp=%h", Y_Data, 32'h12);
        end
        r7_select = 1; alu_instruction = 5'b01111; Z_enable = 1;
        #1;
        checks++;
        if (aluResult !== 64'h168) begin
            failures++;
            $display("[TB] FAIL mul_comb got=%h exp=%h", aluResult, 64'h168);
        end
        tick();
        drive_idle();
        Z_LO_select = 1; LO_enable = 1;
        tick();
        drive_idle();
        Z_HI_select = 1; HI_enable = 1;
        tick();
        drive_idle();
        checks++;
        if (LO_Data !== 32'h168 || HI_Data !== 32'h0) begin
            failures++;
            $display("[TB] FAIL lo_hi got=%h/%h exp=168/0", LO_Data, HI_Data);
        end
    endtask

    task automatic test_mul_signed();
        load_y(32'hFFFF_FFFE);
        load_mdr(32'h3);
        MDR_select = 1; alu_instruction = 5'b01111; Z_enable = 1;
        tick();
        drive_idle();
        checks++;
        if (Z_HI_Data !== 32'hFFFF_FFFF || Z_LO_Data !== 32'hFFFF_FFFA) begin
            failures++;
            $display("[TB] FAIL mul_signed got=%h_%h exp=ffffffff_fffffffa", Z_HI_Data, Z_LO_Data);
        end
    endtask

    task automatic test_pc_wrap();
        load_mdr(32'h5);
        MDR_select = 1; PC_increment_enable = 1; alu_instruction = 5'b00011;
        #1;
        checks++;
        if (aluResult !== 64'h6) begin
            failures++;
            $display("[TB] FAIL pc_inc_override got=%h exp=%h", aluResult, 64'h6);
        end
        drive_idle();
        load_mdr(32'hFFFF_FFFF);
        MDR_select = 1; PC_increment_enable = 1; alu_instruction = 5'b01111; Z_enable = 1;
        #1;
        checks++;
        if (aluResult !== 64'h0) begin
            failures++;
            $display("[TB] FAIL pc_inc_wrap got=%h exp=%h", aluResult, 64'h0);
        end
        tick();
        drive_idle();
        checks++;
        if (Z_HI_Data !== 32'h0 || Z_LO_Data !== 32'h0) begin
            failures++;
            $display("[TB] FAIL pc_wrap_z got=%h_%h exp=0_0", Z_HI_Data, Z_LO_Data);
        end
    endtask

    task automatic test_div();
        logic [31:0] ya [0:2];
        logic [31:0] bv [0:2];
        logic [63:0] ez [0:2];
        ya = '{32'h7, 32'hFFFF_FFF9, 32'h7};
        bv = '{32'h2, 32'h2, 32'h0};
        ez = '{64'h0000_0001_0000_0003, 64'hFFFF_FFFF_FFFF_FFFD, 64'h0};
        for (int i = 0; i < 3; i++) begin
            load_y(ya[i]);
            load_mdr(bv[i]);
            MDR_select = 1; alu_instruction = 5'b10000; Z_enable = 1;
            tick();
            drive_idle();
            checks++;
            if ({Z_HI_Data, Z_LO_Data} !== ez[i]) begin
                failures++;
                $display("[TB] FAIL div_%0d got=%h_%h exp=%h", i, Z_HI_Data, Z_LO_Data, ez[i]);
            end
        end
    endtask

    task automatic test_alu_ops();
        logic [4:0]  op  [0:17];
        logic [63:0] exp [0:17];
        op  = '{5'b00011, 5'b01100, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                5'b01000, 5'b01001, 5'b01010, 5'b01101, 5'b01011, 5'b01110,
                5'b01111, 5'b10000, 5'b10001, 5'b10010, 5'b00000, 5'b11111};
        exp = '{64'h8000_0014, 64'h8000_0014, 64'h8000_000C, 64'h0800_0001,
                64'hF800_0001, 64'h0000_0100, 64'h0800_0001, 64'h0000_0108,
                64'h0, 64'h0, 64'h8000_0014, 64'h8000_0014,
                64'hFFFF_FFFE_0000_0040, 64'hE000_0004, 64'hFFFF_FFFC,
                64'hFFFF_FFFB, 64'h0, 64'h0};
        load_y(32'h8000_0010);
        load_mdr(32'h4);
        MDR_select = 1;
        for (int i = 0; i < 18; i++) begin
            alu_instruction = op[i];
            #1;
            checks++;
            if (aluResult !== exp[i]) begin
                failures++;
                $display("[TB] FAIL alu_op_%b got=%h exp=%h", op[i], aluResult, exp[i]);
            end
        end
        // only B[4:0] sets the shift amount
        load_mdr(32'h24);
        MDR_select = 1; alu_instruction = 5'b00101;
        #1;
        checks++;
        if (aluResult !== 64'h0800_0001) begin
            failures++;
            $display("[TB] FAIL shr_mask got=%h exp=%h", aluResult, 64'h0800_0001);
        end
        // a rotate by zero returns the operand unchanged
        load_mdr(32'h20);
        MDR_select = 1; alu_instruction = 5'b01000;
        #1;
        checks++;
        if (aluResult !== 64'h8000_0010) begin
            failures++;
            $display("[TB] FAIL ror_zero got=%h exp=%h", aluResult, 64'h8000_0010);
        end
        alu_instruction = 5'b01001;
        #1;
        checks++;
        if (aluResult !== 64'h8000_0010) begin
            failures++;
            $display("[TB] FAIL rol_zero got=%h exp=%h", aluResult, 64'h8000_0010);
        end
        drive_idle();
    endtask

    task automatic test_mdr_bus_path();
        drive_idle();
        r7_select = 1; MDR_enable = 1; read = 0; MDataIN = 32'hDEAD_BEEF;
        tick();
        drive_idle();
        checks++;
        if (MDR_Data !== 32'h14) begin
            failures++;
            $display("[TB] FAIL mdr_from_bus got=%h exp=%h", MDR_Data, 32'h14);
        end
    endtask

    task automatic test_back_to_back();
        drive_idle();
        r6_select = 1; r7_enable = 1; MAR_enable = 1; HI_enable = 1;
        Y_enable = 1; LO_enable = 1;
        tick();
        drive_idle();
        checks++;
        if (R7_Data !== 32'h12 || MAR_Data !== 32'h12 || HI_Data !== 32'h12 ||
            Y_Data !== 32'h12 || LO_Data !== 32'h12) begin
            failures++;
            $display("[TB] FAIL simultaneous got=%h/%h/%h/%h/%h exp=12", R7_Data, MAR_Data, HI_Data, Y_Data, LO_Data);
        end
        checks++;
        if (R6_Data !== 32'h12 || PC_Data !== 32'h1 || IR_Data !== 32'h7B38_0000) begin
            failures++;
            $display("[TB] FAIL hold got=%h/%h/%h exp=12/1/7b380000", R6_Data, PC_Data, IR_Data);
        end
    endtask

    task automatic test_clear_midway();
        drive_idle();
        #2;
        clear = 1;
        #1;
        checks++;
        if (R6_Data !== 32'h0 || PC_Data !== 32'h0 || MDR_Data !== 32'h0 ||
            Z_LO_Data !== 32'h0 || Y_Data !== 32'h0) begin
            failures++;
            $display("[TB] FAIL clear_async got=%h/%h/%h/%h/%h exp=0", R6_Data, PC_Data, MDR_Data, Z_LO_Data, Y_Data);
        end
        MDataIN = 32'h55; read = 1; MDR_enable = 1;
        tick();
        checks++;
        if (MDR_Data !== 32'h0) begin
            failures++;
            $display("[TB] FAIL clear_blocks_load got=%h exp=%h", MDR_Data, 32'h0);
        end
        #2;
        clear = 0;
        #1;
        checks++;
        if (MDR_Data !== 32'h0) begin
            failures++;
            $display("[TB] FAIL clear_release got=%h exp=%h", MDR_Data, 32'h0);
        end
        tick();
        checks++;
        if (MDR_Data !== 32'h55) begin
            failures++;
            $display("[TB] FAIL load_after_clear got=%h exp=%h", MDR_Data, 32'h55);
        end
        drive_idle();
        tick();
        checks++;
        if (R6_Data !== 32'h0 || MDR_Data !== 32'h55) begin
            failures++;
            $display("[TB] FAIL no_reload got=%h/%h exp=0/55", R6_Data, MDR_Data);
        end
    endtask

    initial begin
        clear = 0;
        drive_idle();
        test_reset();
        test_encoder();
        test_mdr_transfer();
        test_pc_fetch();
        test_mul_lo_hi();
        test_mul_signed();
        test_pc_wrap();
        test_div();
        test_alu_ops();
        test_mdr_bus_path();
        test_back_to_back();
        test_clear_midway();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
